// File: rtl/pers_ctl_pkg.sv
// Shared types and constants for the PDES personality control block.
package pers_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'd0,
    STAT_DONE    = 2'd1,
    STAT_TIMEOUT = 2'd2
  } status_e;

  localparam logic [17:0] AEG_IDX_ADDR   = 18'd0;
  localparam logic [17:0] AEG_IDX_MASK   = 18'd1;
  localparam logic [17:0] AEG_IDX_TMO    = 18'd2;
  localparam logic [17:0] AEG_IDX_GVT    = 18'd3;
  localparam logic [17:0] AEG_IDX_CYCLES = 18'd4;
  localparam logic [17:0] AEG_CNT        = 18'd5;

  localparam logic [15:0] CSR_STATUS = 16'h0;
  localparam logic [15:0] CSR_GVT    = 16'h1;
  localparam logic [15:0] CSR_CYCLES = 16'h2;
  localparam logic [15:0] CSR_DONE   = 16'h3;

  localparam int EXC_INST = 0;
  localparam int EXC_IDX  = 1;
  localparam int EXC_WR   = 2;
  localparam int EXC_TMO  = 3;

endpackage

// File: rtl/pers_gvt_min.sv
// Combinational pairwise min tree over NUM_ENG GVT values with a per-entry valid mask.
module pers_gvt_min
  import pers_ctl_pkg::*;
#(
  parameter int NUM_ENG = 4,
  parameter int GVT_W   = 14
) (
  input  logic [NUM_ENG*GVT_W-1:0] gvt_i,
  input  logic [NUM_ENG-1:0]       vld_i,
  output logic [GVT_W-1:0]         min_o,
  output logic                     any_o
);

  localparam int LVLS = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 0;
  localparam int N2   = 1 << LVLS;

  logic [N2*GVT_W-1:0] pad_gvt;
  logic [N2-1:0]       pad_vld;
  logic [GVT_W-1:0]    val [N2];
  logic                vld [N2];

  assign pad_gvt = (N2*GVT_W)'(gvt_i);
  assign pad_vld = N2'(vld_i);

  // Pad entries are invalid, so they never win and never set any_o.
  always_comb begin
    for (int i = 0; i < N2; i++) begin
      val[i] = pad_gvt[i*GVT_W +: GVT_W];
      vld[i] = pad_vld[i];
    end
    for (int s = 1; s < N2; s = s * 2) begin
      for (int i = 0; i < N2; i = i + 2 * s) begin
        if (vld[i+s] && (!vld[i] || (val[i+s] < val[i]))) val[i] = val[i+s];
        vld[i] = vld[i] | vld[i+s];
      end
    end
    any_o = vld[0];
    min_o = vld[0] ? val[0] : '0;
  end

endmodule

// File: rtl/pers_ctl.sv
// PDES personality control: AEG register file, run/finish sequencing, done tracking, GVT min.
// state  | meaning
// IDLE   | waiting for caep00; AEG writes accepted
// START  | one-cycle eng_start pulse; counter and done bitmap cleared
// RUN    | count cycles, collect done pulses and GVTs, watch for timeout
// FINISH | latch GVT result, CYCLES and status
module pers_ctl
  import pers_ctl_pkg::*;
#(
  parameter int NUM_ENG = 4,
  parameter int GVT_W   = 14,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     disp_inst_vld,
  input  logic [4:0]               disp_inst,
  input  logic [17:0]              disp_aeg_idx,
  input  logic                     disp_aeg_rd,
  input  logic                     disp_aeg_wr,
  input  logic [63:0]              disp_aeg_wr_data,
  output logic [17:0]              disp_aeg_cnt,
  output logic [15:0]              disp_exception,
  output logic                     disp_idle,
  output logic                     disp_stall,
  output logic                     disp_rtn_data_vld,
  output logic [63:0]              disp_rtn_data,
  output logic                     eng_run,
  output logic [NUM_ENG-1:0]       eng_start,
  output logic [47:0]              eng_addr,
  input  logic [NUM_ENG-1:0]       eng_done,
  input  logic [NUM_ENG*GVT_W-1:0] eng_gvt,
  input  logic                     csr_rd_vld,
  input  logic [15:0]              csr_address,
  output logic                     csr_rd_ack,
  output logic [63:0]              csr_rd_data
);

  state_e                   state_q, state_d;
  status_e                  status_q, fin_status_q;
  logic                     r_start_q;
  logic [63:0]              aeg_addr_q;
  logic [NUM_ENG-1:0]       mask_q;
  logic [CNT_W-1:0]         tmo_q;
  logic [GVT_W-1:0]         gvt_res_q;
  logic [CNT_W-1:0]         cycles_q, cnt_q;
  logic [NUM_ENG-1:0]       done_q;
  logic [NUM_ENG*GVT_W-1:0] gvt_cap_q;
  logic [15:0]              exc_q, exc_d;
  logic                     rtn_vld_q, csr_ack_q;
  logic [63:0]              rtn_data_q, csr_data_q;

  logic                     c_start, idx_ok, wr_ro, wr_ok;
  logic [NUM_ENG-1:0]       done_hit, done_nxt;
  logic                     all_done, tmo_hit;
  logic [CNT_W-1:0]         cnt_inc;
  logic [GVT_W-1:0]         gvt_min;
  logic                     gvt_any;
  logic [63:0]              aeg_rd_val, csr_val;

  assign c_start  = disp_inst_vld && (disp_inst == 5'd0);
  assign done_hit = eng_done & mask_q;
  assign done_nxt = done_q | done_hit;
  assign all_done = ((done_nxt & mask_q) == mask_q);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  // The compare uses the post-increment value so CYCLES equals TMO on a timeout.
  assign tmo_hit  = (tmo_q != '0) && (cnt_inc == tmo_q);

  assign idx_ok = (disp_aeg_idx < AEG_CNT);
  assign wr_ro  = (disp_aeg_idx == AEG_IDX_GVT) || (disp_aeg_idx == AEG_IDX_CYCLES);
  assign wr_ok  = disp_aeg_wr && idx_ok && !wr_ro && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (r_start_q) state_d = ST_START;
      ST_START:  state_d = ST_RUN;
      ST_RUN:    if (all_done || tmo_hit) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exc_d           = '0;
    exc_d[EXC_INST] = disp_inst_vld && (disp_inst != 5'd0);
    exc_d[EXC_IDX]  = (disp_aeg_rd || disp_aeg_wr) && !idx_ok;
    exc_d[EXC_WR]   = disp_aeg_wr && idx_ok && (wr_ro || (state_q != ST_IDLE));
    exc_d[EXC_TMO]  = (state_q == ST_RUN) && !all_done && tmo_hit;
  end

  always_comb begin
    aeg_rd_val = '0;
    case (disp_aeg_idx)
      AEG_IDX_ADDR:   aeg_rd_val = aeg_addr_q;
      AEG_IDX_MASK:   aeg_rd_val = 64'(mask_q);
      AEG_IDX_TMO:    aeg_rd_val = 64'(tmo_q);
      AEG_IDX_GVT:    aeg_rd_val = 64'(gvt_res_q);
      AEG_IDX_CYCLES: aeg_rd_val = 64'(cycles_q);
      default:        aeg_rd_val = '0;
    endcase
  end

  always_comb begin
    csr_val = '0;
    case (csr_address)
      CSR_STATUS: csr_val = {60'b0, status_q, state_q};
      CSR_GVT:    csr_val = 64'(gvt_res_q);
      CSR_CYCLES: csr_val = 64'(cycles_q);
      CSR_DONE:   csr_val = 64'(done_q);
      default:    csr_val = '0;
    endcase
  end

  pers_gvt_min #(.NUM_ENG(NUM_ENG), .GVT_W(GVT_W)) u_gvt_min (
    .gvt_i (gvt_cap_q),
    .vld_i (done_q & mask_q),
    .min_o (gvt_min),
    .any_o (gvt_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      r_start_q  <= 1'b0;
      exc_q      <= '0;
      aeg_addr_q <= '0;
      mask_q     <= '0;
      tmo_q      <= '0;
      rtn_vld_q  <= 1'b0;
      rtn_data_q <= '0;
      csr_ack_q  <= 1'b0;
      csr_data_q <= '0;
    end else begin
      state_q    <= state_d;
      r_start_q  <= c_start;
      exc_q      <= exc_d;
      rtn_vld_q  <= disp_aeg_rd;
      rtn_data_q <= disp_aeg_rd ? aeg_rd_val : '0;
      csr_ack_q  <= csr_rd_vld;
      csr_data_q <= csr_rd_vld ? csr_val : '0;
      if (wr_ok) begin
        case (disp_aeg_idx)
          AEG_IDX_ADDR: aeg_addr_q <= disp_aeg_wr_data;
          AEG_IDX_MASK: mask_q     <= disp_aeg_wr_data[NUM_ENG-1:0];
          AEG_IDX_TMO:  tmo_q      <= disp_aeg_wr_data[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      done_q       <= '0;
      gvt_cap_q    <= '0;
      fin_status_q <= STAT_NONE;
      status_q     <= STAT_NONE;
      gvt_res_q    <= '0;
      cycles_q     <= '0;
    end else begin
      if (state_q == ST_START) begin
        cnt_q  <= '0;
        done_q <= '0;
      end
      if (state_q == ST_RUN) begin
        cnt_q  <= cnt_inc;
        done_q <= done_nxt;
        for (int i = 0; i < NUM_ENG; i++) begin
          if (done_hit[i]) gvt_cap_q[i*GVT_W +: GVT_W] <= eng_gvt[i*GVT_W +: GVT_W];
        end
        if (all_done)     fin_status_q <= STAT_DONE;
        else if (tmo_hit) fin_status_q <= STAT_TIMEOUT;
      end
      if (state_q == ST_FINISH) begin
        status_q  <= fin_status_q;
        gvt_res_q <= gvt_any ? gvt_min : '0;
        cycles_q  <= cnt_q;
      end
    end
  end

  assign disp_aeg_cnt      = AEG_CNT;
  assign disp_exception    = exc_q;
  assign disp_idle         = (state_q == ST_IDLE) && !r_start_q;
  assign disp_stall        = (state_q != ST_IDLE) || c_start || r_start_q;
  assign disp_rtn_data_vld = rtn_vld_q;
  assign disp_rtn_data     = rtn_data_q;
  assign eng_run           = (state_q == ST_START) || (state_q == ST_RUN);
  assign eng_start         = (state_q == ST_START) ? mask_q : '0;
  assign eng_addr          = aeg_addr_q[47:0];
  assign csr_rd_ack        = csr_ack_q;
  assign csr_rd_data       = csr_data_q;

endmodule

// File: tb/tb_pers_ctl.sv
// Directed bench for pers_ctl: AEG/CSR vector table plus hand-timed run sequences.
module tb_pers_ctl;

  localparam int NUM_ENG = 4;
  localparam int GVT_W   = 14;
  localparam int CNT_W   = 32;

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_CSR = 2'd2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     disp_inst_vld = 1'b0;
  logic [4:0]               disp_inst = '0;
  logic [17:0]              disp_aeg_idx = '0;
  logic                     disp_aeg_rd = 1'b0;
  logic                     disp_aeg_wr = 1'b0;
  logic [63:0]              disp_aeg_wr_data = '0;
  logic [17:0]              disp_aeg_cnt;
  logic [15:0]              disp_exception;
  logic                     disp_idle, disp_stall, disp_rtn_data_vld;
  logic [63:0]              disp_rtn_data;
  logic                     eng_run;
  logic [NUM_ENG-1:0]       eng_start;
  logic [47:0]              eng_addr;
  logic [NUM_ENG-1:0]       eng_done = '0;
  logic [NUM_ENG*GVT_W-1:0] eng_gvt = '0;
  logic                     csr_rd_vld = 1'b0;
  logic [15:0]              csr_address = '0;
  logic                     csr_rd_ack;
  logic [63:0]              csr_rd_data;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [17:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
    logic [15:0] exp_exc;
    string       name;
  } vec_t;

  vec_t vecs [16];

  pers_ctl #(.NUM_ENG(NUM_ENG), .GVT_W(GVT_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .disp_inst_vld    (disp_inst_vld),
    .disp_inst        (disp_inst),
    .disp_aeg_idx     (disp_aeg_idx),
    .disp_aeg_rd      (disp_aeg_rd),
    .disp_aeg_wr      (disp_aeg_wr),
    .disp_aeg_wr_data (disp_aeg_wr_data),
    .disp_aeg_cnt     (disp_aeg_cnt),
    .disp_exception   (disp_exception),
    .disp_idle        (disp_idle),
    .disp_stall       (disp_stall),
    .disp_rtn_data_vld(disp_rtn_data_vld),
    .disp_rtn_data    (disp_rtn_data),
    .eng_run          (eng_run),
    .eng_start        (eng_start),
    .eng_addr         (eng_addr),
    .eng_done         (eng_done),
    .eng_gvt          (eng_gvt),
    .csr_rd_vld       (csr_rd_vld),
    .csr_address      (csr_address),
    .csr_rd_ack       (csr_rd_ack),
    .csr_rd_data      (csr_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [NUM_ENG*GVT_W-1:0] pk(input int g0, input int g1, input int g2, input int g3);
    return {14'(g3), 14'(g2), 14'(g1), 14'(g0)};
  endfunction

  task automatic aeg_wr(input logic [17:0] idx, input logic [63:0] data);
    disp_aeg_wr = 1'b1; disp_aeg_idx = idx; disp_aeg_wr_data = data;
    tick();
    disp_aeg_wr = 1'b0;
  endtask

  task automatic aeg_rd(input logic [17:0] idx, output logic [63:0] data);
    disp_aeg_rd = 1'b1; disp_aeg_idx = idx;
    tick();
    data = disp_rtn_data;
    disp_aeg_rd = 1'b0;
  endtask

  task automatic csr_rd(input logic [15:0] addr, output logic [63:0] data);
    csr_rd_vld = 1'b1; csr_address = addr;
    tick();
    data = csr_rd_data;
    csr_rd_vld = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_ENG-1:0] m, input logic [NUM_ENG*GVT_W-1:0] g);
    eng_done = m; eng_gvt = g;
    tick();
    eng_done = '0;
  endtask

  // Issues caep00 from IDLE and returns positioned in the first RUN cycle.
  task automatic run_start(input string tag, input logic [NUM_ENG-1:0] m);
    disp_inst_vld = 1'b1; disp_inst = 5'd0;
    #1;
    check({tag, "_cstart_stall"}, 64'(disp_stall), 64'd1);
    tick();
    disp_inst_vld = 1'b0;
    check({tag, "_rstart_idle"}, 64'(disp_idle), 64'd0);
    tick();
    check({tag, "_start_pulse"}, 64'(eng_start), 64'(m));
    check({tag, "_start_run"}, 64'(eng_run), 64'd1);
    tick();
    check({tag, "_run1_start"}, 64'(eng_start), 64'd0);
    check({tag, "_run1_run"}, 64'(eng_run), 64'd1);
  endtask

  logic [63:0] rd;

  initial begin
    vecs[0]  = '{OP_RD,  18'd0, 64'd0, 64'd0, 16'd0, "rst_addr"};
    vecs[1]  = '{OP_RD,  18'd3, 64'd0, 64'd0, 16'd0, "rst_gvt"};
    vecs[2]  = '{OP_CSR, 18'd0, 64'd0, 64'd0, 16'd0, "rst_csr0"};
    vecs[3]  = '{OP_WR,  18'd0, 64'h0123_4567_89AB_CDEF, 64'd0, 16'd0, "wr_addr"};
    vecs[4]  = '{OP_RD,  18'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 16'd0, "rd_addr"};
    vecs[5]  = '{OP_WR,  18'd1, 64'hFFFF, 64'd0, 16'd0, "wr_mask"};
    vecs[6]  = '{OP_RD,  18'd1, 64'd0, 64'hF, 16'd0, "rd_mask_trunc"};
    vecs[7]  = '{OP_WR,  18'd2, 64'hFFFF_0001_0000_0064, 64'd0, 16'd0, "wr_tmo"};
    vecs[8]  = '{OP_RD,  18'd2, 64'd0, 64'h64, 16'd0, "rd_tmo_trunc"};
    vecs[9]  = '{OP_WR,  18'd3, 64'h55, 64'd0, 16'h4, "wr_ro_gvt"};
    vecs[10] = '{OP_RD,  18'd3, 64'd0, 64'd0, 16'd0, "rd_gvt_kept"};
    vecs[11] = '{OP_WR,  18'd4, 64'h77, 64'd0, 16'h4, "wr_ro_cyc"};
    vecs[12] = '{OP_RD,  18'd7, 64'd0, 64'd0, 16'h2, "rd_bad_idx"};
    vecs[13] = '{OP_WR,  18'd9, 64'h1, 64'd0, 16'h2, "wr_bad_idx"};
    vecs[14] = '{OP_CSR, 18'd7, 64'd0, 64'd0, 16'd0, "csr_other"};
    vecs[15] = '{OP_WR,  18'd2, 64'd0, 64'd0, 16'd0, "wr_tmo_zero"};

    // Reset state
    tick(); tick();
    check("rst_eng_run", 64'(eng_run), 64'd0);
    check("rst_eng_start", 64'(eng_start), 64'd0);
    check("rst_rtn_vld", 64'(disp_rtn_data_vld), 64'd0);
    check("rst_csr_ack", 64'(csr_rd_ack), 64'd0);
    check("rst_exc", 64'(disp_exception), 64'd0);
    check("rst_idle", 64'(disp_idle), 64'd1);
    check("rst_stall", 64'(disp_stall), 64'd0);
    check("rst_aeg_cnt", 64'(disp_aeg_cnt), 64'd5);
    rst_n = 1'b1;
    tick();

    // AEG / CSR vector table
    for (int i = 0; i < 16; i++) begin
      case (vecs[i].op)
        OP_WR:  begin disp_aeg_wr = 1'b1; disp_aeg_idx = vecs[i].addr; disp_aeg_wr_data = vecs[i].data; end
        OP_RD:  begin disp_aeg_rd = 1'b1; disp_aeg_idx = vecs[i].addr; end
        default: begin csr_rd_vld = 1'b1; csr_address = vecs[i].addr[15:0]; end
      endcase
      tick();
      disp_aeg_wr = 1'b0; disp_aeg_rd = 1'b0; csr_rd_vld = 1'b0;
      if (vecs[i].op == OP_RD) begin
        check({vecs[i].name, "_vld"}, 64'(disp_rtn_data_vld), 64'd1);
        check(vecs[i].name, disp_rtn_data, vecs[i].exp);
      end else if (vecs[i].op == OP_CSR) begin
        check({vecs[i].name, "_ack"}, 64'(csr_rd_ack), 64'd1);
        check(vecs[i].name, csr_rd_data, vecs[i].exp);
      end
      check({vecs[i].name, "_exc"}, 64'(disp_exception), 64'(vecs[i].exp_exc));
    end
    check("eng_addr", 64'(eng_addr), 64'h4567_89AB_CDEF);

    // Read and write of the same index in one cycle returns the old value
    disp_aeg_rd = 1'b1; disp_aeg_wr = 1'b1; disp_aeg_idx = 18'd0; disp_aeg_wr_data = 64'hAAAA;
    tick();
    disp_aeg_rd = 1'b0; disp_aeg_wr = 1'b0;
    check("rdwr_old", disp_rtn_data, 64'h0123_4567_89AB_CDEF);
    aeg_rd(18'd0, rd);
    check("rdwr_new", rd, 64'hAAAA);

    // Run 1: all four engines, GVTs 50,12,33,40
    aeg_wr(18'd1, 64'hF);
    run_start("t1", 4'hF);
    pulse(4'b0001, pk(50, 0, 0, 0));
    pulse(4'b0010, pk(0, 12, 0, 0));
    pulse(4'b0100, pk(0, 0, 33, 0));
    pulse(4'b1000, pk(0, 0, 0, 40));
    check("t1_fin_run", 64'(eng_run), 64'd0);
    check("t1_fin_idle", 64'(disp_idle), 64'd0);
    check("t1_fin_stall", 64'(disp_stall), 64'd1);
    tick();
    check("t1_idle", 64'(disp_idle), 64'd1);
    check("t1_stall", 64'(disp_stall), 64'd0);
    csr_rd(16'h1, rd); check("t1_gvt", rd, 64'd12);
    csr_rd(16'h0, rd); check("t1_status", rd, 64'h4);
    csr_rd(16'h3, rd); check("t1_done_map", rd, 64'hF);
    csr_rd(16'h2, rd); check("t1_cycles", rd, 64'd4);
    aeg_rd(18'd3, rd); check("t1_aeg_gvt", rd, 64'd12);
    aeg_rd(18'd4, rd); check("t1_aeg_cycles", rd, 64'd4);

    // Run 2: MASK=5, masked-off engines ignored, repeated done recaptures
    aeg_wr(18'd1, 64'h5);
    run_start("t2", 4'h5);
    pulse(4'b1010, pk(0, 3, 0, 1));
    check("t2_masked_ignored", 64'(eng_run), 64'd1);
    pulse(4'b0001, pk(20, 0, 0, 0));
    pulse(4'b0001, pk(7, 0, 0, 0));
    check("t2_partial", 64'(eng_run), 64'd1);
    pulse(4'b0100, pk(0, 0, 9, 0));
    tick();
    csr_rd(16'h1, rd); check("t2_gvt", rd, 64'd7);
    csr_rd(16'h3, rd); check("t2_done_map", rd, 64'h5);
    csr_rd(16'h2, rd); check("t2_cycles", rd, 64'd4);
    csr_rd(16'h0, rd); check("t2_status", rd, 64'h4);

    // Run 3: TMO=100, only engine 0 completes
    aeg_wr(18'd1, 64'hF);
    aeg_wr(18'd2, 64'd100);
    run_start("t3", 4'hF);
    pulse(4'b0001, pk(20, 0, 0, 0));
    repeat (98) tick();
    check("t3_pre_tmo_run", 64'(eng_run), 64'd1);
    check("t3_pre_tmo_exc", 64'(disp_exception), 64'd0);
    tick();
    check("t3_tmo_exc", 64'(disp_exception), 64'h8);
    check("t3_tmo_run", 64'(eng_run), 64'd0);
    tick();
    check("t3_exc_clear", 64'(disp_exception), 64'd0);
    csr_rd(16'h0, rd); check("t3_status", rd, 64'h8);
    csr_rd(16'h1, rd); check("t3_gvt", rd, 64'd20);
    csr_rd(16'h2, rd); check("t3_cycles", rd, 64'd100);

    // Run 4: last done on the timeout cycle wins
    aeg_wr(18'd1, 64'h1);
    aeg_wr(18'd2, 64'd10);
    run_start("t4", 4'h1);
    repeat (9) tick();
    pulse(4'b0001, pk(5, 0, 0, 0));
    check("t4_no_tmo_exc", 64'(disp_exception), 64'd0);
    check("t4_fin_run", 64'(eng_run), 64'd0);
    tick();
    csr_rd(16'h0, rd); check("t4_status", rd, 64'h4);
    csr_rd(16'h1, rd); check("t4_gvt", rd, 64'd5);
    csr_rd(16'h2, rd); check("t4_cycles", rd, 64'd10);

    // Run 5: MASK=0 exits on the first RUN cycle
    aeg_wr(18'd1, 64'h0);
    aeg_wr(18'd2, 64'd0);
    run_start("t5", 4'h0);
    tick();
    check("t5_fin_run", 64'(eng_run), 64'd0);
    tick();
    csr_rd(16'h0, rd); check("t5_status", rd, 64'h4);
    csr_rd(16'h1, rd); check("t5_gvt", rd, 64'd0);
    csr_rd(16'h2, rd); check("t5_cycles", rd, 64'd1);
    pulse(4'hF, pk(1, 1, 1, 1));
    csr_rd(16'h3, rd); check("t5_idle_done_ignored", rd, 64'd0);

    // Run 6: exceptions raised while running
    aeg_wr(18'd1, 64'hF);
    run_start("t6", 4'hF);
    aeg_wr(18'd0, 64'hDEAD);
    check("t6_wr_busy_exc", 64'(disp_exception), 64'h4);
    aeg_wr(18'd3, 64'h1);
    check("t6_wr_ro_exc", 64'(disp_exception), 64'h4);
    aeg_rd(18'd7, rd);
    check("t6_rd_idx_exc", 64'(disp_exception), 64'h2);
    disp_inst_vld = 1'b1; disp_inst = 5'd2;
    tick();
    disp_inst_vld = 1'b0; disp_inst = 5'd0;
    check("t6_inst_exc", 64'(disp_exception), 64'h1);
    pulse(4'hF, pk(9, 9, 9, 9));
    tick();
    check("t6_idle", 64'(disp_idle), 64'd1);
    aeg_rd(18'd0, rd); check("t6_addr_dropped", rd, 64'hAAAA);

    // Run 7: reset mid-run, then a clean run
    run_start("t7", 4'hF);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t7_rst_run", 64'(eng_run), 64'd0);
    check("t7_rst_idle", 64'(disp_idle), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    aeg_rd(18'd0, rd); check("t7_addr_rst", rd, 64'd0);
    aeg_rd(18'd1, rd); check("t7_mask_rst", rd, 64'd0);
    aeg_rd(18'd2, rd); check("t7_tmo_rst", rd, 64'd0);
    aeg_rd(18'd3, rd); check("t7_gvt_rst", rd, 64'd0);
    csr_rd(16'h0, rd); check("t7_csr0_rst", rd, 64'd0);
    aeg_wr(18'd1, 64'h3);
    run_start("t7b", 4'h3);
    pulse(4'b0011, pk(6, 4, 0, 0));
    tick();
    csr_rd(16'h1, rd); check("t7_gvt", rd, 64'd4);
    csr_rd(16'h0, rd); check("t7_status", rd, 64'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pers_ctl.md
# pers_ctl

Parametrised personality control block for the PDES personality. It sits between the dispatch/CSR interfaces and an array of `NUM_ENG` phold engines. It owns the AEG register file, the run/finish state machine with an optional cycle timeout, and per-engine done tracking. It reduces the engines' GVTs to a single minimum GVT result and exposes status over CSR.

## Interface
Parameters:
- `NUM_ENG`, 4: number of phold engines, 1..16.
- `GVT_W`, 14: width of each engine's GVT, 1..32.
- `CNT_W`, 32: width of the run-cycle counter and of the timeout field, 8..64.

Ports:
- `clk`  in  1: personality clock; the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `disp_inst_vld`  in  1: instruction valid.
- `disp_inst`  in  5: instruction code.
- `disp_aeg_idx`  in  18: AEG index.
- `disp_aeg_rd`, `disp_aeg_wr`  in  1 each: AEG read/write strobes.
- `disp_aeg_wr_data`  in  64: AEG write data.
- `disp_aeg_cnt`  out  18: constant 5.
- `disp_exception`  out  16: exception bits.
- `disp_idle`, `disp_stall`  out  1 each.
- `disp_rtn_data_vld`  out  1, `disp_rtn_data`  out  64: AEG read return.
- `eng_run`  out  1: engine enable level; engines are held in reset while low.
- `eng_start`  out  NUM_ENG: one-cycle start pulse per enabled engine.
- `eng_addr`  out  48: AEG0[47:0].
- `eng_done`  in  NUM_ENG: per-engine completion pulse.
- `eng_gvt`  in  NUM_ENG*GVT_W: engine i's GVT at bits [i*GVT_W +: GVT_W], valid with its done pulse.
- `csr_rd_vld`  in  1, `csr_address`  in  16: CSR read request.
- `csr_rd_ack`  out  1, `csr_rd_data`  out  64: CSR read response.

## Operation
AEG map (index: name, access):
- 0: ADDR, rw.
- 1: MASK, rw; only bits [NUM_ENG-1:0] are stored.
- 2: TMO, rw; low CNT_W bits; 0 disables the timeout.
- 3: GVT result, ro.
- 4: CYCLES, ro.

Exceptions:
- bit0: `disp_inst_vld` with `disp_inst` != 0.
- bit1: AEG rd/wr with idx >= 5.
- bit2: write to AEG 3/4, or AEG write while not IDLE. The write is dropped.
- bit3: run ended by timeout.
- Bits 15:4 are 0. All exception bits are one-cycle pulses, registered one cycle after their cause.

Instruction 0 (caep00) starts a run. The state machine has states IDLE, START, RUN, FINISH:
- IDLE -> START: one cycle after a registered caep00.
- START -> RUN: `eng_start` = MASK for one cycle; the cycle counter is cleared and the done bitmap is cleared.
- RUN -> FINISH: on either condition:
  - (done bitmap & MASK) == MASK → status DONE.
  - TMO != 0 and counter == TMO → status TIMEOUT.
- FINISH -> IDLE: GVT result, CYCLES and status are latched in FINISH.

RUN details:
- The counter increments once per RUN cycle and saturates at all-ones.
- Each `eng_done[i]` with MASK[i]=1 sets done bit i and captures that engine's `eng_gvt`.
- Done pulses from masked-off engines, and any done pulse outside RUN, are ignored.
- A repeated done pulse recaptures that engine's GVT.

Result rules:
- GVT result = zero-extended minimum of the captured GVTs of enabled engines.
- MASK == 0: RUN exits on its first cycle with status DONE and GVT result 0.
- On TIMEOUT, GVT result is the minimum over engines that have completed, or 0 if none has.
- Last done and timeout in the same cycle → status DONE; bit3 is not raised.

Dispatch outputs:
- `eng_run` = 1 in START and RUN only.
- `disp_idle` = (IDLE && !r_start).
- `disp_stall` = (!IDLE || c_start || r_start).

CSR map:
- 0x0: {60'b0, status[1:0], state[1:0]}; status 0 = none, 1 = DONE, 2 = TIMEOUT.
- 0x1: GVT result.
- 0x2: CYCLES.
- 0x3: {zeros, done bitmap}.
- Other addresses return 0.

## Timing
- AEG read: data is valid the cycle after `disp_aeg_rd`. A read of the same index in the same cycle as a write returns the old value.
- CSR read: ack and data are valid the cycle after `csr_rd_vld`.
- Cycle accounting:
  - caep00 at cycle T: START at T+2, first RUN cycle at T+3.
  - Last done at cycle D: FINISH at D+1, IDLE and new results visible at D+2.
- Reset values:
  - All AEGs 0, state IDLE, status 0.
  - `eng_run`, `eng_start`, `disp_rtn_data_vld`, `csr_rd_ack`, `disp_exception` all 0.
  - `disp_idle` = 1, `disp_stall` = 0, `disp_aeg_cnt` = 5.
- Reset asserted mid-run: everything returns to reset values immediately, with no FINISH latch.

## Structure
- Package `pers_ctl_pkg` holds:
  - The state enum.
  - AEG index constants and `AEG_CNT=5`.
  - CSR address constants.
  - The status code enum and the exception bit positions.
- Sub-module `pers_gvt_min`: a combinational, parametrised min tree over NUM_ENG x GVT_W values with a per-entry valid mask. It outputs the minimum and an any-valid flag; an all-invalid input yields 0.

## Test plan
- MASK=0xF, TMO=0; caep00; done pulses with GVTs 50, 12, 33, 40 → GVT result 12, status DONE, CSR 0x3 = 0xF, `disp_idle` returns to 1.
- MASK=0x5; done pulses on all four engines, GVTs 7, 3, 9, 1 → GVT result 7, since engines 1 and 3 are ignored.
- TMO=100; only engine 0 finishes (GVT 20) → CYCLES=100, exception bit3 pulses, status TIMEOUT, GVT result 20.
- Last done arrives on the timeout cycle → status DONE, no bit3.
- During RUN, AEG write to idx 0, AEG write to idx 3, read of idx 7, and `disp_inst`=2 → the write is dropped, bits 2, 2, 1 and 0 pulse respectively.
- Deassert `rst_n` mid-RUN → `eng_run`=0 immediately, all AEGs read 0, CSR 0x0 reads 0; a new caep00 then completes normally.
